// File: rtl/usart_recv_pkg.sv
// Shared constants, state encodings and frame layout for the status-link receiver.
package usart_recv_pkg;

    localparam int FRAME_LEN = 5;
    localparam int ADDR_W    = 2;
    localparam int MOD_W     = 6;
    localparam int DATA_W    = 24;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [1:0] F_IDLE    = 2'd0;
    localparam logic [1:0] F_COLLECT = 2'd1;
    localparam logic [1:0] F_COMMIT  = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MOD_W-1:0]  mode;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Reserved upper bits of the address and mode bytes must be zero.
    function automatic logic frame_ok(input logic [7:0] b1, input logic [7:0] b2);
        return (b1[7:ADDR_W] == '0) && (b2[7:MOD_W] == '0);
    endfunction

endpackage

// File: rtl/usart_recv_uart_recv.sv
// 8N1 byte receiver: synchronizer, mid-bit sampling, stop-bit check.
//   state   | meaning
//   R_IDLE  | waiting for falling edge on synchronized line
//   R_START | timing start bit, mid-bit sample rejects glitches
//   R_DATA  | shifting in 8 data bits, LSB first
//   R_STOP  | sample stop bit at its midpoint, then back to idle
module uart_recv
    import usart_recv_pkg::*;
#(
    parameter logic [15:0] BPS_CNT = 16'd434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic       rx_done,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam logic [15:0] HALF_CNT = BPS_CNT / 16'd2;
    localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;

    logic       meta_q, sync_q, prev_q;
    logic [1:0] state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       done_q, done_d, ferr_q, ferr_d;
    logic       mid, wrap;

    assign mid  = (cnt_q == HALF_CNT);
    assign wrap = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = 16'd0;
                bit_d = 3'd0;
                if (prev_q && !sync_q) state_d = R_START;
            end
            R_START: begin
                if (mid && sync_q) begin
                    state_d = R_IDLE;
                    cnt_d   = 16'd0;
                end else if (wrap) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (mid) shift_d = {sync_q, shift_q[7:1]};
                if (wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (mid) begin
                    state_d = R_IDLE;
                    cnt_d   = 16'd0;
                    if (sync_q) begin
                        done_d = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Synchronizer resets low so a line held low through reset release is not an edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= R_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= uart_rxd;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_done = done_q;
    assign rx_byte = byte_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/usart_recv.sv
// Status-link frame receiver: assembles 5 UART bytes, validates, updates outputs atomically.
//   state     | meaning
//   F_IDLE    | no partial frame held
//   F_COLLECT | bytes 2..5 pending, gap timer running
//   F_COMMIT  | one-cycle slot where frame_done/frame_err is presented
module usart_recv
    import usart_recv_pkg::*;
#(
    parameter logic [15:0] BPS_CNT     = 16'd434,
    parameter logic [31:0] TIMEOUT_CNT = 32'd13020
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] D,
    output logic [ADDR_W-1:0] Adress,
    output logic [MOD_W-1:0]  Mod_SEL,
    output logic              frame_done,
    output logic              frame_err
);

    logic       rx_done, rx_ferr;
    logic [7:0] rx_byte;

    uart_recv #(.BPS_CNT(BPS_CNT)) u_uart_recv (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .rx_done  (rx_done),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    logic [1:0]                 state_q, state_d;
    logic [2:0]                 idx_q, idx_d;
    logic [FRAME_LEN:1][7:0]    byte_buf_q, byte_buf_d;
    logic [31:0]                gap_q, gap_d;
    frame_t                     out_q, out_d;
    logic                       done_q, done_d, err_q, err_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_buf_d = byte_buf_q;
        gap_d      = gap_q;
        out_d      = out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            F_IDLE: begin
                idx_d = 3'd0;
                gap_d = 32'd0;
                if (rx_ferr) begin
                    err_d = 1'b1;
                end else if (rx_done) begin
                    byte_buf_d[1] = rx_byte;
                    idx_d         = 3'd1;
                    state_d       = F_COLLECT;
                end
            end
            F_COLLECT: begin
                if (rx_ferr) begin
                    err_d   = 1'b1;
                    idx_d   = 3'd0;
                    gap_d   = 32'd0;
                    state_d = F_IDLE;
                end else if (rx_done) begin
                    byte_buf_d[idx_q + 3'd1] = rx_byte;
                    idx_d = idx_q + 3'd1;
                    gap_d = 32'd0;
                    // Validate on the final byte so results appear in the commit cycle.
                    if (idx_q == 3'(FRAME_LEN - 1)) begin
                        state_d = F_COMMIT;
                        if (frame_ok(byte_buf_q[1], byte_buf_q[2])) begin
                            done_d     = 1'b1;
                            out_d.addr = byte_buf_q[1][ADDR_W-1:0];
                            out_d.mode = byte_buf_q[2][MOD_W-1:0];
                            out_d.data = {byte_buf_q[3], byte_buf_q[4], rx_byte};
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (gap_q >= TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    idx_d   = 3'd0;
                    gap_d   = 32'd0;
                    state_d = F_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            F_COMMIT: begin
                idx_d   = 3'd0;
                gap_d   = 32'd0;
                state_d = F_IDLE;
                if (rx_ferr) err_d = 1'b1;
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= F_IDLE;
            idx_q      <= 3'd0;
            byte_buf_q <= '0;
            gap_q      <= 32'd0;
            out_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_buf_q <= byte_buf_d;
            gap_q      <= gap_d;
            out_q      <= out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign D          = out_q.data;
    assign Adress     = out_q.addr;
    assign Mod_SEL    = out_q.mode;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_usart_recv.sv
// Directed bench for usart_recv: table of frames plus glitch and mid-frame reset sequences.
module tb_usart_recv;

    localparam int BPS     = 32;
    localparam int TMO     = 960;
    localparam int LAT     = 9 * BPS + BPS / 2 + 5;
    localparam int TMO_LAT = LAT + 1 + TMO;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        frame_done, frame_err;

    usart_recv #(.BPS_CNT(16'd32), .TIMEOUT_CNT(32'd960)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .uart_rxd   (uart_rxd),
        .D          (D),
        .Adress     (Adress),
        .Mod_SEL    (Mod_SEL),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int done_cnt = 0, err_cnt = 0, dbl_cnt = 0, pulse_cyc = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (frame_done) begin
                done_cnt++;
                pulse_cyc = cyc;
                if (done_prev) dbl_cnt++;
            end
            if (frame_err) begin
                err_cnt++;
                pulse_cyc = cyc;
                if (err_prev) dbl_cnt++;
            end
        end
        done_prev = frame_done;
        err_prev  = frame_err;
    end

    int n_vec = 0, n_bad = 0;
    int last_start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(posedge sys_clk); #1;
        uart_rxd = 1'b0;
        last_start_cyc = cyc;
        repeat (BPS) @(posedge sys_clk); #1;
        for (int k = 0; k < 8; k++) begin
            uart_rxd = b[k];
            repeat (BPS) @(posedge sys_clk); #1;
        end
        uart_rxd = stop_v;
        repeat (BPS) @(posedge sys_clk); #1;
        uart_rxd = 1'b1;
    endtask

    typedef struct {
        logic [39:0] bytes;
        int          nbytes;
        int          bad_idx;
        int          idle_after;
        int          exp_done;
        int          exp_err;
        int          lat;
        logic [1:0]  ea;
        logic [5:0]  em;
        logic [23:0] ed;
    } vec_t;

    vec_t vt[8];

    initial begin
        int d0, e0;
        vt[0] = '{40'h02_15_A5_5A_3C, 5, -1,   64, 1, 0, LAT,     2'd2, 6'h15, 24'hA55A3C};
        vt[1] = '{40'h02_15_A5_5A_3C, 3,  2,   64, 0, 1, LAT,     2'd2, 6'h15, 24'hA55A3C};
        vt[2] = '{40'h01_3F_00_00_01, 5, -1,   64, 1, 0, LAT,     2'd1, 6'h3F, 24'h000001};
        vt[3] = '{40'h02_15_A5_5A_3C, 2, -1, 1500, 0, 1, TMO_LAT, 2'd1, 6'h3F, 24'h000001};
        vt[4] = '{40'h00_00_FF_FF_FF, 5, -1,   64, 1, 0, LAT,     2'd0, 6'h00, 24'hFFFFFF};
        vt[5] = '{40'h06_15_11_22_33, 5, -1,   64, 0, 1, LAT,     2'd0, 6'h00, 24'hFFFFFF};
        vt[6] = '{40'h01_40_11_22_33, 5, -1,   64, 0, 1, LAT,     2'd0, 6'h00, 24'hFFFFFF};
        vt[7] = '{40'h02_15_A5_5A_3C, 5, -1,   64, 1, 0, LAT,     2'd2, 6'h15, 24'hA55A3C};

        repeat (5) @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_D", 32'(D), 32'h0);
        chk("rst_Adress", 32'(Adress), 32'h0);
        chk("rst_Mod_SEL", 32'(Mod_SEL), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);

        // Short low glitch on an idle line must be rejected silently.
        d0 = done_cnt; e0 = err_cnt;
        @(posedge sys_clk); #1;
        uart_rxd = 1'b0;
        repeat (10) @(posedge sys_clk); #1;
        uart_rxd = 1'b1;
        repeat (4 * BPS) @(posedge sys_clk); #1;
        chk("glitch_done", 32'(done_cnt - d0), 32'd0);
        chk("glitch_err", 32'(err_cnt - e0), 32'd0);

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            for (int j = 0; j < vt[i].nbytes; j++)
                send_byte(vt[i].bytes[39 - 8 * j -: 8], (j != vt[i].bad_idx));
            repeat (vt[i].idle_after) @(posedge sys_clk); #1;
            chk($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(vt[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vt[i].exp_err));
            if (vt[i].exp_done + vt[i].exp_err == 1)
                chk($sformatf("v%0d_latency", i), 32'(pulse_cyc - last_start_cyc), 32'(vt[i].lat));
            chk($sformatf("v%0d_Adress", i), 32'(Adress), 32'(vt[i].ea));
            chk($sformatf("v%0d_Mod_SEL", i), 32'(Mod_SEL), 32'(vt[i].em));
            chk($sformatf("v%0d_D", i), 32'(D), 32'(vt[i].ed));
        end

        // Reset in the middle of byte 4, released while the line is still low.
        send_byte(8'h03, 1'b1);
        send_byte(8'h2A, 1'b1);
        send_byte(8'h12, 1'b1);
        @(posedge sys_clk); #1;
        uart_rxd = 1'b0;
        repeat (5) @(posedge sys_clk);
        #5 sys_rst = 1'b1;
        #2;
        chk("midrst_D", 32'(D), 32'h0);
        chk("midrst_Adress", 32'(Adress), 32'h0);
        chk("midrst_Mod_SEL", 32'(Mod_SEL), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (2 * BPS) @(posedge sys_clk); #1;
        uart_rxd = 1'b1;
        repeat (3 * BPS) @(posedge sys_clk); #1;
        chk("postrst_done", 32'(done_cnt - d0), 32'd0);
        chk("postrst_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h03, 1'b1);
        send_byte(8'h2A, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        repeat (64) @(posedge sys_clk); #1;
        chk("postrst_frame_done", 32'(done_cnt - d0), 32'd1);
        chk("postrst_frame_err", 32'(err_cnt - e0), 32'd0);
        chk("postrst_Adress", 32'(Adress), 32'h3);
        chk("postrst_Mod_SEL", 32'(Mod_SEL), 32'h2A);
        chk("postrst_D", 32'(D), 32'h123456);

        chk("pulse_width", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
